pr_banked: RTL
==============

# pr_banked

Parametrised successor to the P-R register unit. It holds R0 (CPU flags plus user bits) and BANKS banks of user registers R1..R(2^AW-1), and drives the L bus. It also adds a context-dump engine that streams one bank out over a valid/ready handshake for interrupt context save. It sits between the W bus (writes), the ALU flag sources, and the L bus (reads) inside the CPU.

## Interface
Parameters:
- WIDTH, 16, register/bus width; legal values are 16 or greater. Bit 0 is the MSB.
- AW, 3, register address width; addresses 1..2^AW-1 select user registers, 0 selects R0.
- BANKS, 2, number of user register banks; BW = max(1, clog2(BANKS)).

Ports:
- __clk  in  1  system clock, rising edge
- __rst_  in  1  reset, asynchronous, active-low
- w  in  WIDTH  W bus write data
- addr  in  AW  register select for read and write
- bank  in  BW  bank select for read and write
- we  in  1  write strobe, single cycle
- blr  in  1  L bus carries {0…0, R0[0:7]} instead of the selected register
- w_bar  in  1  load Q from w[10]
- zer  in  1  synchronous clear of Q and R0
- ust_z, ust_mc, ust_v, ust_leg  in  1 each  flag update enables
- zs, s_1, s0, carry, aryt, ovf  in  1 each  ALU flag sources
- awp_fp, awp_zmvc  in  1, 4  AWP flag strobe and data (used only with PR_AWP_EN)
- l  out  WIDTH  L bus, combinational read
- r0  out  9  R0[0:8] = Z M V C L E G Y X
- q  out  1  user-mode flag
- dump_req  in  1  start dump of dump_bank
- dump_bank  in  BW  bank to dump
- dump_ready  in  1  consumer accepts a beat
- dump_valid  out  1  beat valid
- dump_idx  out  AW  register index of the current beat
- dump_data  out  WIDTH  register value of the current beat
- dump_busy  out  1  dump engine not idle
- dump_done  out  1  one-cycle pulse after the last beat is accepted

## Operation
- Reset values: all registers 0, R0 = 0, q = 0, dump_valid/busy/done = 0, dump_idx = 0, FSM in IDLE.
- Write, we=1 and addr≠0: updates user register [bank][addr] at the clock edge.
- Write, we=1 and addr=0:
  - q=0: the whole R0 is written.
  - q=1: only R0[8:WIDTH-1] is written; bits 0..7 are kept.
- L bus:
  - blr=1: l = {(WIDTH-8) zeros, R0[0:7]}.
  - else addr=0: l = R0.
  - else: l = [bank][addr].
- Flag updates (each takes effect at the edge):
  - ust_z: Z←zs.
  - ust_mc: M←s0, C←carry.
  - ust_v: V←V|ovf (sticky).
  - ust_leg: L←aryt?s_1:~carry; E←zs; G←aryt?~(zs|s_1):(carry&~zs).
- Same-cycle priority: zer, then we to R0, then AWP strobe, then ust_* updates. Flags not covered by the winning source still update from their ust_* enable.
- Q: w_bar loads q←w[10]. zer clears q. zer wins over w_bar.
- Dump FSM states:
  - IDLE: dump_req → LOAD; idx←1; the bank is latched from dump_bank.
  - LOAD: one cycle. Asserts dump_valid; goes to SEND.
  - SEND: dump_data = live value of [latched bank][idx]. On valid&ready: if idx=2^AW-1 → DONE, else idx+1 and stay in SEND.
  - DONE: dump_done=1 for one cycle, then IDLE.
- dump_req is ignored while busy.
- Writes to the bank being dumped are allowed. Beats still to come carry the new value; beats already sent are not re-sent.
- dump_valid stays high and dump_idx/dump_data stay stable while dump_ready=0, except that dump_data follows a same-register write.
- Reset mid-dump: immediate return to IDLE, no dump_done pulse.

## Timing
- Write to read latency is 1 cycle: a value written at edge n is visible on l after edge n.
- Flags and q update at the edge following their enables.
- Dump with dump_ready held 1 and AW=3: dump_req sampled at edge 0; dump_valid high for cycles 2..8 (idx 1..7); dump_done high in cycle 9; dump_busy high for cycles 1..9.
- Each dump_ready=0 cycle adds one cycle of stall.
- Maximum dump rate is one beat per cycle.

## Configuration
- PR_AWP_EN defined: awp_fp=1 loads {Z,M,V,C}←awp_zmvc[0:3], but only when q=0.
- PR_AWP_EN undefined: awp_fp and awp_zmvc are ignored, and the block synthesises no AWP logic.

## Test plan
- Reset, then write bank 1 R5=16'hA5A5, bank 0 R5=16'h1234 → with addr=5: l=A5A5 for bank=1, l=1234 for bank=0.
- q=1 and we R0 with w=16'hFFFF → R0=16'h00FF. q=0, same write → R0=FFFF. Then blr=1 → l=16'h00FF.
- ust_leg, aryt=0, carry=1, zs=0 → L=0, E=0, G=1. Then ust_v with ovf=1, then ovf=0 → V stays 1. Then zer → R0=0, q=0.
- Dump bank 1 with registers loaded 1..7 and ready=1 → 7 beats, idx 1..7, data 1..7, dump_done in cycle 9. Repeat with ready toggling every cycle → beats unchanged, done in cycle 16.
- During a dump, when idx=3 write R6=16'hBEEF; assert __rst_ low while idx=5 → the first run shows beat 6 = BEEF; the reset run shows dump_valid=0 immediately, no done pulse, and dump_busy=0.
- With PR_AWP_EN: awp_fp, zmvc=4'b1010, q=0 → Z=1, M=0, V=1, C=0. With q=1 → no change. Without the macro → no change in either case.

Source files
------------

// File: rtl/pr_banked.sv
// pr_banked: banked P-R register file with R0 flags, Q user-mode bit and a bank dump engine.
// Defining PR_AWP_EN compiles in the AWP {Z,M,V,C} load path.
module pr_banked #(
    parameter int unsigned  WIDTH = 16,
    parameter int unsigned  AW    = 3,
    parameter int unsigned  BANKS = 2,
    localparam int unsigned BW    = (BANKS > 1) ? $clog2(BANKS) : 1
) (
    input  logic             __clk,
    input  logic             __rst_,
    input  logic [WIDTH-1:0] w,
    input  logic [AW-1:0]    addr,
    input  logic [BW-1:0]    bank,
    input  logic             we,
    input  logic             blr,
    input  logic             w_bar,
    input  logic             zer,
    input  logic             ust_z,
    input  logic             ust_mc,
    input  logic             ust_v,
    input  logic             ust_leg,
    input  logic             zs,
    input  logic             s_1,
    input  logic             s0,
    input  logic             carry,
    input  logic             aryt,
    input  logic             ovf,
    input  logic             awp_fp,
    input  logic [3:0]       awp_zmvc,
    output logic [WIDTH-1:0] l,
    output logic [8:0]       r0,
    output logic             q,
    input  logic             dump_req,
    input  logic [BW-1:0]    dump_bank,
    input  logic             dump_ready,
    output logic             dump_valid,
    output logic [AW-1:0]    dump_idx,
    output logic [WIDTH-1:0] dump_data,
    output logic             dump_busy,
    output logic             dump_done
);

    localparam int unsigned NREG = 1 << AW;
    localparam int unsigned LAST = NREG - 1;
    // Bit 0 (MSB-first numbering) sits at vector position WIDTH-1.
    localparam int unsigned ZB = WIDTH - 1;
    localparam int unsigned MB = WIDTH - 2;
    localparam int unsigned VB = WIDTH - 3;
    localparam int unsigned CB = WIDTH - 4;
    localparam int unsigned LB = WIDTH - 5;
    localparam int unsigned EB = WIDTH - 6;
    localparam int unsigned GB = WIDTH - 7;
    localparam int unsigned QB = WIDTH - 11;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_DONE} state_e;

    logic [WIDTH-1:0] regs_q [BANKS][NREG];
    logic [WIDTH-1:0] r0_q, r0_d;
    logic             q_q, q_d;
    state_e           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [BW-1:0]    dbank_q, dbank_d;
    logic             valid_q, valid_d, busy_q, busy_d, done_q, done_d;

`ifndef PR_AWP_EN
    logic awp_unused_c;
    assign awp_unused_c = ^{awp_fp, awp_zmvc};
`endif

    // User register file; index 0 of each bank is never written (R0 lives separately).
    always_ff @(posedge __clk or negedge __rst_) begin
        if (!__rst_) begin
            regs_q <= '{default: '0};
        end else if (we && addr != '0) begin
            regs_q[bank][addr] <= w;
        end
    end

    // R0 next value: flag enables, then AWP, then W-bus write, then zer on top.
    always_comb begin
        r0_d = r0_q;
        if (ust_z) r0_d[ZB] = zs;
        if (ust_mc) begin
            r0_d[MB] = s0;
            r0_d[CB] = carry;
        end
        if (ust_v) r0_d[VB] = r0_q[VB] | ovf;
        if (ust_leg) begin
            r0_d[LB] = aryt ? s_1 : ~carry;
            r0_d[EB] = zs;
            r0_d[GB] = aryt ? ~(zs | s_1) : (carry & ~zs);
        end
`ifdef PR_AWP_EN
        if (awp_fp && !q_q) r0_d[ZB:CB] = awp_zmvc;
`endif
        if (we && addr == '0) begin
            if (q_q) r0_d[WIDTH-9:0] = w[WIDTH-9:0];
            else     r0_d = w;
        end
        if (zer) r0_d = '0;
    end

    always_comb begin
        q_d = q_q;
        if (w_bar) q_d = w[QB];
        if (zer)   q_d = 1'b0;
    end

    always_ff @(posedge __clk or negedge __rst_) begin
        if (!__rst_) begin
            r0_q <= '0;
            q_q  <= 1'b0;
        end else begin
            r0_q <= r0_d;
            q_q  <= q_d;
        end
    end

    always_comb begin
        l = regs_q[bank][addr];
        if (addr == '0) l = r0_q;
        if (blr)        l = {(WIDTH-8)'(0), r0_q[WIDTH-1 -: 8]};
    end

    assign r0 = r0_q[WIDTH-1 -: 9];
    assign q  = q_q;

    always_ff @(posedge __clk or negedge __rst_) begin
        if (!__rst_) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            dbank_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dbank_q <= dbank_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Dump engine: walks idx 1..LAST of the latched bank, one beat per accepted handshake.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dbank_d = dbank_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (dump_req) begin
                    state_d = S_LOAD;
                    idx_d   = AW'(1);
                    dbank_d = dump_bank;
                    busy_d  = 1'b1;
                end
            end
            S_LOAD: begin
                state_d = S_SEND;
                valid_d = 1'b1;
            end
            S_SEND: begin
                if (valid_q && dump_ready) begin
                    if (idx_q == AW'(LAST)) begin
                        state_d = S_DONE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + AW'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                idx_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign dump_valid = valid_q;
    assign dump_idx   = idx_q;
    assign dump_data  = regs_q[dbank_q][idx_q];
    assign dump_busy  = busy_q;
    assign dump_done  = done_q;

endmodule
